// File: rtl/uart_frame_parser.sv
// Purpose: hunts SYNC/LEN/payload/CHK frames in UART byte strobes and releases only checksum-good payloads.
// Latency: first payload byte is valid 1 clk after the CHK strobe; frame_ok/frame_err pulse 1 clk after the deciding event.
// Backpressure: out_ready low holds out_data/out_last; bytes arriving while draining are dropped and flagged as overrun.
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_PAYLOAD    = 16,
  parameter int         TIMEOUT_CYCLES = 8680
) (
  input  logic       clk,
  input  logic       areset,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int PTR_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ERR_OVERRUN = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       chk_q, chk_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] rd_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [7:0]       last_idx;
  logic             timed;
  logic             len_bad;
  logic             mem_we;

  logic [7:0]       out_data_d;
  logic             out_valid_d;
  logic             out_last_d;
  logic             frame_ok_d;
  logic             frame_err_d;
  logic [1:0]       err_code_d;

  logic [7:0]       pay_mem [MAX_PAYLOAD];

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    chk_d       = chk_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code;
    mem_we      = 1'b0;

    rd_inc   = rd_q + PTR_W'(1);
    cnt_inc  = cnt_q + CNT_W'(1);
    last_idx = len_q - 8'd1;
    len_bad  = (rx_byte == 8'd0) || (rx_byte > 8'(MAX_PAYLOAD));
    timed    = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);

    // Inter-byte idle counter: any strobe restarts it, otherwise it climbs toward the limit.
    if (timed) begin
      cnt_d = rx_valid ? '0 : cnt_inc;
    end

    case (state_q)
      ST_HUNT: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          state_d = ST_LEN;
          cnt_d   = '0;
        end
      end

      ST_LEN: begin
        if (rx_valid) begin
          if (len_bad) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = ST_HUNT;
          end else begin
            len_d   = rx_byte;
            chk_d   = rx_byte;
            wr_d    = '0;
            state_d = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (rx_valid) begin
          mem_we = 1'b1;
          chk_d  = chk_q ^ rx_byte;
          wr_d   = wr_q + PTR_W'(1);
          if (8'(wr_q) == last_idx) begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        if (rx_valid) begin
          if (rx_byte == chk_q) begin
            frame_ok_d  = 1'b1;
            rd_d        = '0;
            out_valid_d = 1'b1;
            out_data_d  = pay_mem[0];
            out_last_d  = (len_q == 8'd1);
            state_d     = ST_DRAIN;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
            state_d     = ST_HUNT;
          end
        end
      end

      ST_DRAIN: begin
        // A byte landing here has nowhere to go; flag it and keep draining.
        if (rx_valid) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
        if (out_valid && out_ready) begin
          if (out_last) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = ST_HUNT;
          end else begin
            rd_d       = rd_inc;
            out_data_d = pay_mem[rd_inc];
            out_last_d = (8'(rd_inc) == last_idx);
          end
        end
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase

    // A strobe in the same cycle always wins over the timeout.
    if (timed && !rx_valid && (cnt_inc == CNT_W'(TIMEOUT_CYCLES))) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      state_d     = ST_HUNT;
    end
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!areset) begin
      state_q   <= ST_HUNT;
      len_q     <= '0;
      chk_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_OVERRUN;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      chk_q     <= chk_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      frame_ok  <= frame_ok_d;
      frame_err <= frame_err_d;
      err_code  <= err_code_d;
      busy      <= (state_d != ST_HUNT);
    end
  end

  // Payload buffer write port; contents need no reset since reads follow writes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      pay_mem[wr_q] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Purpose: randomized and directed stimulus for uart_frame_parser with a queue-based scoreboard.
// Latency: expected events/bytes are queued at stimulus time and popped when the DUT presents them.
// Backpressure: out_ready is driven always-high, random, or held low depending on the phase.
module tb_uart_frame_parser;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         MAXP = 16;
  localparam int         TO   = 40;

  logic       clk = 1'b0;
  logic       areset;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  always #5 clk = ~clk;

  uart_frame_parser #(
    .SYNC_BYTE     (SYNC),
    .MAX_PAYLOAD   (MAXP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .areset   (areset),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .busy     (busy)
  );

  typedef logic [7:0] bq_t[$];
  typedef struct packed {logic is_err; logic [1:0] code;} ev_t;
  typedef struct packed {logic [7:0] dat; logic last;} db_t;

  ev_t exp_ev[$];
  db_t exp_db[$];
  int  checks = 0;
  int  errors = 0;
  int  rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_ev(input logic is_err, input logic [1:0] code);
    ev_t e;
    e.is_err = is_err;
    e.code   = code;
    exp_ev.push_back(e);
  endfunction

  // Reference model: decide the outcome of one SYNC-led frame from its bytes alone.
  function automatic void model_frame(input bq_t f);
    int         len;
    logic [7:0] x;
    db_t        d;
    len = int'(f[1]);
    if (len == 0 || len > MAXP) begin
      push_ev(1'b1, 2'b01);
      return;
    end
    x = f[1];
    for (int i = 0; i < len; i++) x = x ^ f[2 + i];
    if (f[2 + len] == x) begin
      push_ev(1'b0, 2'b00);
      for (int i = 0; i < len; i++) begin
        d.dat  = f[2 + i];
        d.last = (i == len - 1);
        exp_db.push_back(d);
      end
    end else begin
      push_ev(1'b1, 2'b10);
    end
  endfunction

  function automatic bq_t make_frame(input int len, input bit corrupt);
    bq_t        f;
    logic [7:0] x;
    logic [7:0] b;
    f.push_back(SYNC);
    f.push_back(8'(len));
    x = 8'(len);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      f.push_back(b);
      x = x ^ b;
    end
    if (corrupt) x = x ^ 8'($urandom_range(1, 255));
    f.push_back(x);
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input bq_t f, input int max_gap);
    model_frame(f);
    foreach (f[i]) begin
      send_byte(f[i]);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic send_garbage(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      do b = 8'($urandom); while (b == SYNC);
      send_byte(b);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_ev.size() != 0 || exp_db.size() != 0 || busy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_budget", 32'(n < 600), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_last"},  32'(out_last),  0);
    chk({tag, "_frame_ok"},  32'(frame_ok),  0);
    chk({tag, "_frame_err"}, 32'(frame_err), 0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_out_data"},  32'(out_data),  0);
    chk({tag, "_err_code"},  32'(err_code),  0);
  endtask

  // Consumer: drives out_ready according to the current phase.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops and compares expected events and payload bytes as the DUT presents them.
  initial begin : monitor
    logic       held;
    logic [7:0] held_dat;
    logic       held_last;
    ev_t        e;
    db_t        d;
    held      = 1'b0;
    held_dat  = '0;
    held_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!areset) begin
        held = 1'b0;
      end else begin
        if (frame_ok || frame_err) begin
          if (exp_ev.size() == 0) begin
            chk("unexpected_event", 32'({frame_ok, frame_err, err_code}), 0);
          end else begin
            e = exp_ev.pop_front();
            chk("event_err_pulse", 32'(frame_err), 32'(e.is_err));
            chk("event_ok_pulse",  32'(frame_ok),  32'(!e.is_err));
            if (e.is_err) chk("err_code", 32'(err_code), 32'(e.code));
          end
        end
        if (out_valid) begin
          if (held) begin
            chk("hold_out_data", 32'(out_data), 32'(held_dat));
            chk("hold_out_last", 32'(out_last), 32'(held_last));
          end
          if (out_ready) begin
            if (exp_db.size() == 0) begin
              chk("unexpected_byte", 32'({1'b1, out_last, out_data}), 0);
            end else begin
              d = exp_db.pop_front();
              chk("out_data", 32'(out_data), 32'(d.dat));
              chk("out_last", 32'(out_last), 32'(d.last));
            end
          end
          held      = !out_ready;
          held_dat  = out_data;
          held_last = out_last;
        end else begin
          if (held) chk("valid_dropped_while_stalled", 32'(out_valid), 1);
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    bq_t f;
    int  k;
    areset   = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    idle(2);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    areset = 1'b1;
    idle(2);

    // Directed good frame with cycle-exact streaming checks.
    f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_frame(f, 0);
    @(negedge clk);
    chk("first_byte_latency", 32'(out_valid), 1);
    chk("frame_ok_pulse", 32'(frame_ok), 1);
    @(negedge clk);
    chk("frame_ok_one_cycle", 32'(frame_ok), 0);
    chk("stream_second_byte", 32'({out_valid, out_last}), 32'(2'b10));
    @(negedge clk);
    chk("stream_last_byte", 32'({out_valid, out_last}), 32'(2'b11));
    @(negedge clk);
    chk("back_to_hunt", 32'({out_valid, busy}), 0);
    wait_idle();

    // Checksum error, then a good frame still gets through.
    f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    send_frame(f, 0);
    wait_idle();
    send_frame(make_frame(5, 1'b0), 1);
    wait_idle();

    // Bad lengths; trailing non-SYNC bytes are ignored.
    f = '{8'hA5, 8'h00};
    send_frame(f, 0);
    send_garbage(4);
    f = '{8'hA5, 8'h11};
    send_frame(f, 0);
    send_garbage(4);
    wait_idle();

    // Length boundaries.
    send_frame(make_frame(1, 1'b0), 2);
    wait_idle();
    send_frame(make_frame(MAXP, 1'b0), 2);
    wait_idle();

    // Timeout fires exactly TO clocks after the last strobe.
    push_ev(1'b1, 2'b11);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    k = 0;
    while (k < TO + 10) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (frame_err) break;
    end
    chk("timeout_latency", 32'(k), 32'(TO));
    #1;
    wait_idle();

    // A byte on the final idle cycle prevents the timeout.
    f = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h31};
    model_frame(f);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    repeat (TO - 1) @(posedge clk);
    #1;
    send_byte(8'h22);
    send_byte(8'h31);
    wait_idle();

    // Random frames with random backpressure and occasional corruption.
    rdy_mode = 1;
    for (int i = 0; i < 12; i++) begin
      send_frame(make_frame($urandom_range(1, MAXP), ($urandom_range(0, 3) == 0)), 3);
      wait_idle();
    end

    // Overrun: bytes (including a SYNC) sent while draining is stalled.
    rdy_mode = 2;
    send_frame(make_frame(8, 1'b0), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drain_active_for_overrun", 32'(out_valid), 1);
      if (out_valid) begin
        push_ev(1'b1, 2'b00);
        rx_byte  = (i == 1) ? SYNC : 8'($urandom);
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        idle(1);
      end
    end
    rdy_mode = 1;
    wait_idle();
    rdy_mode = 0;
    send_frame(make_frame(4, 1'b0), 0);
    wait_idle();

    // Reset in the middle of a payload.
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    areset = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("reset_mid_payload");
    areset = 1'b1;
    send_frame(make_frame(6, 1'b0), 1);
    wait_idle();

    // Reset while a drain is stalled.
    rdy_mode = 2;
    send_frame(make_frame(5, 1'b0), 0);
    idle(3);
    chk("stalled_in_drain", 32'(out_valid), 1);
    areset = 1'b0;
    @(posedge clk);
    #1;
    exp_db.delete();
    check_reset_vals("reset_mid_drain");
    areset   = 1'b1;
    rdy_mode = 0;
    send_frame(make_frame(7, 1'b0), 1);
    wait_idle();

    chk("ev_queue_empty", 32'(exp_ev.size()), 0);
    chk("db_queue_empty", 32'(exp_db.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
